// File: rtl/regex_cpu_local_fifo.sv
// ==== regex_cpu_local_fifo : regex thread core with a local SPLIT-target FIFO ====
// ==== rev 1.0 ====
`default_nettype none

module regex_cpu_local_fifo #(
  parameter int PC_WIDTH          = 9,
  parameter int CC_ID_BITS        = 2,
  parameter int CHARACTER_WIDTH   = 8,
  parameter int MEMORY_WIDTH      = 20,
  parameter int MEMORY_ADDR_WIDTH = 11,
  parameter int LOCAL_FIFO_DEPTH  = 4
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic [CHARACTER_WIDTH*(2**CC_ID_BITS)-1:0]    current_characters,
  input  logic [(2**CC_ID_BITS)-1:0]                    end_of_string,
  input  logic                                          input_pc_valid,
  output logic                                          input_pc_ready,
  input  logic [PC_WIDTH-1:0]                           input_pc,
  input  logic [CC_ID_BITS-1:0]                         input_cc_id,
  output logic                                          memory_valid,
  input  logic                                          memory_ready,
  output logic [MEMORY_ADDR_WIDTH-1:0]                  memory_addr,
  input  logic [MEMORY_WIDTH-1:0]                       memory_data,
  output logic                                          output_pc_valid,
  input  logic                                          output_pc_ready,
  output logic [PC_WIDTH-1:0]                           output_pc,
  output logic [CC_ID_BITS-1:0]                         output_cc_id,
  output logic [(2**CC_ID_BITS)-1:0]                    elaborating_chars,
  output logic                                          accepts,
  output logic                                          running,
  output logic [$clog2(LOCAL_FIFO_DEPTH):0]             local_fifo_count
);

  localparam int NUM_SLOTS         = 2**CC_ID_BITS;
  localparam int DATA_WIDTH        = 2*CHARACTER_WIDTH;
  localparam int INSTRUCTION_WIDTH = 4 + DATA_WIDTH;
  localparam int PTR_WIDTH         = $clog2(LOCAL_FIFO_DEPTH);
  localparam int CNT_WIDTH         = PTR_WIDTH + 1;

  localparam logic [3:0] OP_ACCEPT                = 4'd0;
  localparam logic [3:0] OP_SPLIT                 = 4'd1;
  localparam logic [3:0] OP_MATCH                 = 4'd2;
  localparam logic [3:0] OP_JMP                   = 4'd3;
  localparam logic [3:0] OP_END_WITHOUT_ACCEPTING = 4'd4;
  localparam logic [3:0] OP_MATCH_ANY             = 4'd5;
  localparam logic [3:0] OP_ACCEPT_PARTIAL        = 4'd6;
  localparam logic [3:0] OP_NOT_MATCH             = 4'd7;
  localparam logic [3:0] OP_MATCH_RANGE           = 4'd8;
  localparam logic [3:0] OP_NOT_MATCH_RANGE       = 4'd9;

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_FETCH_SEND = 2'd1,
    S_FETCH_REC  = 2'd2,
    S_EXEC       = 2'd3
  } state_t;

  state_t                         state, state_next;
  logic [PC_WIDTH-1:0]            curr_pc, pc_next;
  logic [CC_ID_BITS-1:0]          curr_cc_id, cc_next;
  logic [INSTRUCTION_WIDTH-1:0]   instruction, instruction_next;

  logic [PC_WIDTH-1:0]            fifo_pc [LOCAL_FIFO_DEPTH];
  logic [CC_ID_BITS-1:0]          fifo_cc [LOCAL_FIFO_DEPTH];
  logic [PTR_WIDTH-1:0]           rd_ptr, wr_ptr;
  logic [CNT_WIDTH-1:0]           count;
  logic                           push, pop;

  logic [3:0]                     opcode;
  logic [DATA_WIDTH-1:0]          data;
  logic [CHARACTER_WIDTH-1:0]     chr, lo, hi;
  logic [PC_WIDTH-1:0]            pc_inc, data_pc;
  logic [CC_ID_BITS-1:0]          cc_inc;
  logic                           fifo_full, match_hit;

  // Character comparisons use the low data byte; ranges use {hi, lo}.
  assign opcode    = instruction[INSTRUCTION_WIDTH-1 -: 4];
  assign data      = instruction[DATA_WIDTH-1:0];
  assign lo        = data[CHARACTER_WIDTH-1:0];
  assign hi        = data[DATA_WIDTH-1:CHARACTER_WIDTH];
  assign chr       = current_characters[int'(curr_cc_id)*CHARACTER_WIDTH +: CHARACTER_WIDTH];
  assign pc_inc    = curr_pc + PC_WIDTH'(1);
  assign cc_inc    = curr_cc_id + CC_ID_BITS'(1);
  assign data_pc   = data[PC_WIDTH-1:0];
  assign fifo_full = (count == CNT_WIDTH'(LOCAL_FIFO_DEPTH));

  assign local_fifo_count  = count;
  assign running           = (state != S_IDLE) || (count != '0);
  assign elaborating_chars = (state != S_IDLE) ? (NUM_SLOTS'(1) << curr_cc_id) : '0;

  always_comb begin
    match_hit = 1'b0;
    case (opcode)
      OP_MATCH:       match_hit = (chr == lo);
      OP_MATCH_RANGE: match_hit = (chr >= lo) && (chr <= hi);
      OP_MATCH_ANY:   match_hit = 1'b1;
      default:        match_hit = 1'b0;
    endcase
  end

  always_comb begin
    state_next       = state;
    pc_next          = curr_pc;
    cc_next          = curr_cc_id;
    instruction_next = instruction;
    push             = 1'b0;
    pop              = 1'b0;
    input_pc_ready   = 1'b0;
    memory_valid     = 1'b0;
    memory_addr      = '0;
    output_pc_valid  = 1'b0;
    output_pc        = '0;
    output_cc_id     = '0;
    accepts          = 1'b0;

    case (state)
      S_IDLE: begin
        // Parked local threads always win over new work from the scheduler.
        if (count != '0) begin
          pop        = 1'b1;
          pc_next    = fifo_pc[rd_ptr];
          cc_next    = fifo_cc[rd_ptr];
          state_next = S_FETCH_SEND;
        end else begin
          input_pc_ready = 1'b1;
          if (input_pc_valid) begin
            pc_next    = input_pc;
            cc_next    = input_cc_id;
            state_next = S_FETCH_SEND;
          end
        end
      end

      S_FETCH_SEND: begin
        memory_valid = 1'b1;
        memory_addr  = MEMORY_ADDR_WIDTH'(curr_pc);
        if (memory_ready) state_next = S_FETCH_REC;
      end

      S_FETCH_REC: begin
        instruction_next = memory_data[INSTRUCTION_WIDTH-1:0];
        state_next       = S_EXEC;
      end

      S_EXEC: begin
        state_next = S_IDLE;
        case (opcode)
          OP_JMP: begin
            pc_next    = data_pc;
            state_next = S_FETCH_SEND;
          end
          OP_NOT_MATCH: begin
            if (chr != lo) begin
              pc_next    = pc_inc;
              state_next = S_FETCH_SEND;
            end
          end
          OP_NOT_MATCH_RANGE: begin
            if ((chr < lo) || (chr > hi)) begin
              pc_next    = pc_inc;
              state_next = S_FETCH_SEND;
            end
          end
          OP_SPLIT: begin
            if (!fifo_full) begin
              push       = 1'b1;
              pc_next    = pc_inc;
              state_next = S_FETCH_SEND;
            end else begin
              // Overflowed target goes out to the scheduler; fallthrough waits.
              output_pc_valid = 1'b1;
              output_pc       = data_pc;
              output_cc_id    = curr_cc_id;
              if (output_pc_ready) begin
                pc_next    = pc_inc;
                state_next = S_FETCH_SEND;
              end else begin
                state_next = S_EXEC;
              end
            end
          end
          OP_MATCH, OP_MATCH_RANGE, OP_MATCH_ANY: begin
            if (match_hit) begin
              output_pc_valid = 1'b1;
              output_pc       = pc_inc;
              output_cc_id    = cc_inc;
              if (!output_pc_ready) state_next = S_EXEC;
            end
          end
          OP_ACCEPT:         accepts = end_of_string[curr_cc_id];
          OP_ACCEPT_PARTIAL: accepts = 1'b1;
          default:           state_next = S_IDLE;
        endcase
      end

      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      curr_pc     <= '0;
      curr_cc_id  <= '0;
      instruction <= {OP_END_WITHOUT_ACCEPTING, {DATA_WIDTH{1'b0}}};
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
    end else begin
      state       <= state_next;
      curr_pc     <= pc_next;
      curr_cc_id  <= cc_next;
      instruction <= instruction_next;
      if (push) begin
        wr_ptr <= wr_ptr + PTR_WIDTH'(1);
        count  <= count + CNT_WIDTH'(1);
      end else if (pop) begin
        rd_ptr <= rd_ptr + PTR_WIDTH'(1);
        count  <= count - CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc[wr_ptr] <= data_pc;
      fifo_cc[wr_ptr] <= curr_cc_id;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_regex_cpu_local_fifo.sv
// ==== tb_regex_cpu_local_fifo : randomized bench with instruction-level reference model ====
// ==== rev 1.0 ====
`default_nettype none

module tb_regex_cpu_local_fifo;

  localparam int DEPTH = 2;

  localparam int OP_ACCEPT = 0, OP_SPLIT = 1, OP_MATCH = 2, OP_JMP = 3, OP_END = 4;
  localparam int OP_MATCH_ANY = 5, OP_ACCEPT_PARTIAL = 6, OP_NOT_MATCH = 7;
  localparam int OP_MATCH_RANGE = 8, OP_NOT_MATCH_RANGE = 9;
  localparam int EV_FETCH = 0, EV_OUT = 1, EV_ACC = 2;

  typedef struct {
    int kind;
    int pc;
    int cc;
    int cnt;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] current_characters;
  logic [3:0]  eos = '0;
  logic        input_pc_valid = 1'b0;
  logic        input_pc_ready;
  logic [8:0]  input_pc = '0;
  logic [1:0]  input_cc_id = '0;
  logic        memory_valid;
  logic        memory_ready = 1'b1;
  logic [10:0] memory_addr;
  logic [19:0] memory_data = '0;
  logic        output_pc_valid;
  logic        output_pc_ready = 1'b1;
  logic [8:0]  output_pc;
  logic [1:0]  output_cc_id;
  logic [3:0]  elaborating_chars;
  logic        accepts;
  logic        running;
  logic [1:0]  local_fifo_count;

  logic [7:0]  ch [4];
  logic [19:0] mem [0:511];
  ev_t         exp_q[$];
  int          fetch_log[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  bit          rand_mode = 0;
  logic        dir_mr = 1'b1;
  logic        dir_or = 1'b1;

  assign current_characters = {ch[3], ch[2], ch[1], ch[0]};

  regex_cpu_local_fifo #(
    .PC_WIDTH(9), .CC_ID_BITS(2), .CHARACTER_WIDTH(8), .MEMORY_WIDTH(20),
    .MEMORY_ADDR_WIDTH(11), .LOCAL_FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .current_characters(current_characters), .end_of_string(eos),
    .input_pc_valid(input_pc_valid), .input_pc_ready(input_pc_ready),
    .input_pc(input_pc), .input_cc_id(input_cc_id),
    .memory_valid(memory_valid), .memory_ready(memory_ready),
    .memory_addr(memory_addr), .memory_data(memory_data),
    .output_pc_valid(output_pc_valid), .output_pc_ready(output_pc_ready),
    .output_pc(output_pc), .output_cc_id(output_cc_id),
    .elaborating_chars(elaborating_chars), .accepts(accepts),
    .running(running), .local_fifo_count(local_fifo_count)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #900000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference: run a thread and every local thread it parks, instruction by instruction.
  task automatic model_burst(input int pc0, input int cc0);
    int qpc[$];
    int qcc[$];
    int pc, cc, op, d, c, lo, hi, steps;
    bit alive;
    pc = pc0; cc = cc0; steps = 0;
    forever begin
      alive = 1;
      while (alive) begin
        steps++;
        if (steps > 2000) begin
          checks++; errors++;
          $display("FAIL model_runaway actual=%0d required=bounded", steps);
          return;
        end
        exp_q.push_back('{EV_FETCH, pc, cc, qpc.size()});
        op = int'(mem[pc][19:16]);
        d  = int'(mem[pc][15:0]);
        c  = int'(ch[cc]);
        lo = d % 256;
        hi = d / 256;
        alive = 0;
        case (op)
          OP_JMP: begin pc = d % 512; alive = 1; end
          OP_NOT_MATCH: if (c != lo) begin pc = (pc + 1) % 512; alive = 1; end
          OP_NOT_MATCH_RANGE: if (c < lo || c > hi) begin pc = (pc + 1) % 512; alive = 1; end
          OP_SPLIT: begin
            if (qpc.size() < DEPTH) begin
              qpc.push_back(d % 512);
              qcc.push_back(cc);
            end else begin
              exp_q.push_back('{EV_OUT, d % 512, cc, qpc.size()});
            end
            pc = (pc + 1) % 512;
            alive = 1;
          end
          OP_MATCH, OP_MATCH_RANGE, OP_MATCH_ANY: begin
            if ((op == OP_MATCH && c == lo) || (op == OP_MATCH_ANY) ||
                (op == OP_MATCH_RANGE && c >= lo && c <= hi))
              exp_q.push_back('{EV_OUT, (pc + 1) % 512, (cc + 1) % 4, qpc.size()});
          end
          OP_ACCEPT: if (eos[cc]) exp_q.push_back('{EV_ACC, 0, cc, 0});
          OP_ACCEPT_PARTIAL: exp_q.push_back('{EV_ACC, 0, cc, 0});
          default: ;
        endcase
      end
      if (qpc.size() == 0) return;
      pc = qpc.pop_front();
      cc = qcc.pop_front();
    end
  endtask

  initial forever begin
    @(posedge clk);
    #2;
    if (rand_mode) begin
      memory_ready    = ($urandom_range(0, 3) != 0);
      output_pc_ready = ($urandom_range(0, 2) != 0);
    end else begin
      memory_ready    = dir_mr;
      output_pc_ready = dir_or;
    end
  end

  // Scoreboard: every handshake and accept pulse is matched in order against the model.
  initial begin
    bit prev_mem_stall = 0, prev_out_stall = 0, prev_acc = 0, mem_hs_prev = 0, hs;
    logic [10:0] prev_addr = '0;
    logic [10:0] prev_out = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        prev_mem_stall = 0; prev_out_stall = 0; prev_acc = 0; mem_hs_prev = 0;
        continue;
      end
      if (input_pc_ready) begin
        chk("idle_mem_valid", memory_valid, 0);
        chk("idle_out_valid", output_pc_valid, 0);
        chk("idle_fifo_count", local_fifo_count, 0);
        chk("idle_elab", elaborating_chars, 0);
        chk("idle_running", running, 0);
        if (input_pc_valid) begin
          chk("inject_queue_empty", exp_q.size(), 0);
          model_burst(int'(input_pc), int'(input_cc_id));
        end
      end
      if (prev_mem_stall) chk("mem_hold", {memory_valid, memory_addr}, {1'b1, prev_addr});
      if (prev_out_stall) chk("out_hold", {output_pc_valid, output_pc, output_cc_id}, {1'b1, prev_out});
      hs = memory_valid && memory_ready;
      if (memory_valid) begin
        chk("mem_addr_upper", memory_addr[10:9], 0);
        chk("running_fetch", running, 1);
        if (exp_q.size() == 0 || exp_q[0].kind != EV_FETCH) begin
          checks++; errors++;
          $display("FAIL fetch_unexpected actual=addr %0d required=no fetch", memory_addr);
        end else begin
          chk("fetch_addr", memory_addr, exp_q[0].pc);
          chk("fetch_cc", elaborating_chars, 32'd1 << exp_q[0].cc);
          chk("fetch_fifo_count", local_fifo_count, exp_q[0].cnt);
          if (hs) void'(exp_q.pop_front());
        end
        if (hs) fetch_log.push_back(int'(memory_addr));
      end
      if (output_pc_valid) begin
        chk("running_out", running, 1);
        if (exp_q.size() == 0 || exp_q[0].kind != EV_OUT) begin
          checks++; errors++;
          $display("FAIL out_unexpected actual=pc %0d cc %0d required=no output", output_pc, output_cc_id);
        end else begin
          chk("out_pc", output_pc, exp_q[0].pc);
          chk("out_cc", output_cc_id, exp_q[0].cc);
          chk("out_fifo_count", local_fifo_count, exp_q[0].cnt);
          if (output_pc_ready) void'(exp_q.pop_front());
        end
      end
      if (accepts) begin
        chk("accepts_pulse", prev_acc, 0);
        if (exp_q.size() == 0 || exp_q[0].kind != EV_ACC) begin
          checks++; errors++;
          $display("FAIL accept_unexpected actual=1 required=0");
        end else begin
          chk("accept_cc", elaborating_chars, 32'd1 << exp_q[0].cc);
          void'(exp_q.pop_front());
        end
      end
      prev_acc       = accepts;
      prev_mem_stall = memory_valid && !memory_ready;
      prev_addr      = memory_addr;
      prev_out_stall = output_pc_valid && !output_pc_ready;
      prev_out       = {output_pc, output_cc_id};
      if (hs) memory_data = mem[memory_addr[8:0]];
      else if (!mem_hs_prev) memory_data = 20'($urandom);
      mem_hs_prev = hs;
    end
  end

  task automatic clear_mem();
    for (int a = 0; a < 512; a++) mem[a] = {4'(OP_END), 16'h0};
  endtask

  task automatic gen_program();
    int r, op, d, lo, hi;
    clear_mem();
    for (int a = 0; a < 16; a++) begin
      r  = (a == 15) ? $urandom_range(8, 10) : $urandom_range(0, 12);
      lo = 97 + $urandom_range(0, 3);
      hi = lo + $urandom_range(0, 2);
      d  = hi * 256 + lo;
      case (r)
        0:  begin op = OP_JMP; d = a + $urandom_range(1, 15 - a); end
        1:  begin
              if (a < 8) begin op = OP_SPLIT; d = $urandom_range(12, 15); end
              else op = OP_MATCH_ANY;
            end
        2, 3: op = OP_MATCH;
        4:  op = OP_MATCH_RANGE;
        5:  op = OP_MATCH_ANY;
        6:  op = OP_NOT_MATCH;
        7:  op = OP_NOT_MATCH_RANGE;
        8:  op = OP_ACCEPT;
        9:  op = OP_ACCEPT_PARTIAL;
        10: op = OP_MATCH;
        11: op = OP_END;
        default: op = 14;
      endcase
      mem[a] = {4'(op), 16'(d)};
    end
  endtask

  task automatic inject(input int pc, input int cc, output int t0);
    @(posedge clk); #1;
    input_pc_valid = 1'b1;
    input_pc       = 9'(pc);
    input_cc_id    = 2'(cc);
    t0 = -1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (input_pc_ready) begin t0 = cyc; break; end
    end
    chk("inject_accepted", 32'(t0 >= 0), 1);
    @(posedge clk); #1;
    input_pc_valid = 1'b0;
  endtask

  task automatic wait_out(output int t);
    t = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (output_pc_valid) begin t = cyc; break; end
    end
    chk("out_seen", 32'(t >= 0), 1);
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (input_pc_ready && exp_q.size() == 0 && !input_pc_valid) begin ok = 1; break; end
    end
    chk("idle_reached", 32'(ok), 1);
  endtask

  initial begin
    int t0, t1, t2;
    bit drained;
    for (int i = 0; i < 4; i++) ch[i] = 8'h00;
    clear_mem();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_input_ready", input_pc_ready, 1);
    chk("reset_mem_valid", memory_valid, 0);
    chk("reset_mem_addr", memory_addr, 0);
    chk("reset_out_valid", output_pc_valid, 0);
    chk("reset_fifo_count", local_fifo_count, 0);
    chk("reset_running", running, 0);
    chk("reset_elab", elaborating_chars, 0);
    chk("reset_accepts", accepts, 0);

    // MATCH 'a' then ACCEPT: output at cycle 3, accept pulse at cycle 3
    mem[0] = {4'(OP_MATCH), 16'h0061};
    mem[1] = {4'(OP_ACCEPT), 16'h0000};
    ch[0] = 8'h61;
    inject(0, 0, t0);
    wait_out(t1);
    chk("match_latency", t1 - t0, 3);
    chk("match_out_pc", output_pc, 1);
    chk("match_out_cc", output_cc_id, 1);
    wait_idle();
    eos = 4'b0010;
    inject(1, 1, t0);
    t1 = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (accepts) begin t1 = cyc; break; end
    end
    chk("accept_latency", t1 - t0, 3);
    wait_idle();

    // SPLIT 5: fallthrough output first, parked target after one idle pop cycle
    clear_mem();
    mem[0] = {4'(OP_SPLIT), 16'd5};
    mem[1] = {4'(OP_MATCH_ANY), 16'd0};
    mem[5] = {4'(OP_MATCH_ANY), 16'd0};
    inject(0, 3, t0);
    wait_out(t1);
    chk("split_out1_pc", output_pc, 2);
    chk("split_out1_cc", output_cc_id, 0);
    chk("split_count1", local_fifo_count, 1);
    wait_out(t2);
    chk("split_gap", t2 - t1, 4);
    chk("split_out2_pc", output_pc, 6);
    chk("split_out2_cc", output_cc_id, 0);
    chk("split_count0", local_fifo_count, 0);
    wait_idle();

    // Overflowing SPLIT chain: third target held on the output port, then reset
    clear_mem();
    mem[0]  = {4'(OP_SPLIT), 16'd10};
    mem[1]  = {4'(OP_SPLIT), 16'd11};
    mem[2]  = {4'(OP_SPLIT), 16'd12};
    for (int a = 10; a < 13; a++) mem[a] = {4'(OP_MATCH_ANY), 16'd0};
    mem[20] = {4'(OP_ACCEPT_PARTIAL), 16'd0};
    dir_or = 1'b0;
    inject(0, 1, t0);
    wait_out(t1);
    chk("ovf_out_pc", output_pc, 12);
    chk("ovf_out_cc", output_cc_id, 1);
    chk("ovf_count", local_fifo_count, 2);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("ovf_hold_valid", output_pc_valid, 1);
      chk("ovf_hold_pc", output_pc, 12);
      chk("ovf_hold_cc", output_cc_id, 1);
    end
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", output_pc_valid, 0);
    chk("rst_count", local_fifo_count, 0);
    chk("rst_input_ready", input_pc_ready, 1);
    chk("rst_running", running, 0);
    @(posedge clk); #1 rst = 1'b0;

    // Pending input is refused while parked threads drain
    inject(0, 1, t0);
    wait_out(t1);
    @(posedge clk); #1;
    dir_or = 1'b1;
    input_pc_valid = 1'b1;
    input_pc = 9'd20;
    input_cc_id = 2'd0;
    drained = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (local_fifo_count != 0) chk("fifo_blocks_input", input_pc_ready, 0);
      if (input_pc_ready) begin drained = 1; break; end
    end
    chk("fifo_drained", 32'(drained), 1);
    @(posedge clk); #1 input_pc_valid = 1'b0;
    wait_idle();

    // Memory stall on the first fetch, then JMP to the top address and wrap
    clear_mem();
    mem[20]  = {4'(OP_JMP), 16'd511};
    mem[511] = {4'(OP_NOT_MATCH), 16'h007A};
    mem[0]   = {4'(OP_ACCEPT_PARTIAL), 16'd0};
    ch[2] = 8'h61;
    fetch_log.delete();
    dir_mr = 1'b0;
    inject(20, 2, t0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("stall_mem_valid", memory_valid, 1);
      chk("stall_mem_addr", memory_addr, 20);
    end
    @(posedge clk); #1 dir_mr = 1'b1;
    wait_idle();
    chk("wrap_fetch_count", fetch_log.size(), 3);
    if (fetch_log.size() == 3) begin
      chk("wrap_fetch0", fetch_log[0], 20);
      chk("wrap_fetch1", fetch_log[1], 511);
      chk("wrap_fetch2", fetch_log[2], 0);
    end

    // Randomized programs, characters and handshake back-pressure
    rand_mode = 1;
    for (int it = 0; it < 150; it++) begin
      if (it % 10 == 0) gen_program();
      for (int i = 0; i < 4; i++) ch[i] = 8'(97 + $urandom_range(0, 3));
      eos = 4'($urandom);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      inject($urandom_range(0, 15), $urandom_range(0, 3), t0);
      wait_idle();
    end
    rand_mode = 0;
    repeat (3) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
